// File: rtl/spi_master_gen.sv
// Parametrised SPI master: shifts out {slave-ID, address, data} MSB first with
// selectable CPOL/CPHA, runtime half-period divider and decoded chip selects.
module spi_master_gen #(
  parameter int ID_W   = 8,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int NUM_SS = 4,
  parameter int CS_W   = 2,
  parameter int DIV_W  = 10,
  parameter logic [ID_W-1:0] SLAVE_IDW = ID_W'(8'hff),
  parameter logic [ID_W-1:0] SLAVE_IDR = ID_W'(8'h00)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              wr,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic [1:0]        mode,
  input  logic [DIV_W-1:0]  div,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic [NUM_SS-1:0] ss,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso
);

  localparam int F  = ID_W + ADDR_W + DATA_W;
  localparam int EW = $clog2(2 * F + 1);

  typedef enum logic [2:0] {IDLE, LEAD, XFER, TRAIL, GUARD} state_t;

  state_t            state;
  logic [DIV_W-1:0]  cnt;
  logic [DIV_W-1:0]  div_q;
  logic [EW-1:0]     edge_cnt;
  logic [F-1:0]      tx;
  logic [DATA_W-1:0] rx;
  logic              cpha_q;
  logic              wr_q;

  logic [F-1:0]      frame;
  logic [NUM_SS-1:0] ss_dec;
  logic [EW-1:0]     next_edge;
  logic              wrap;
  logic              last_edge;
  logic              sample_now;
  logic              shift_now;

  // Frame assembly and chip-select decode from the live inputs, used only at accept.
  always_comb begin
    frame  = wr ? {SLAVE_IDW, addr, wdata} : {SLAVE_IDR, addr, {DATA_W{1'b0}}};
    ss_dec = '1;
    for (int i = 0; i < NUM_SS; i++) begin
      if (int'(cs_sel) == i) ss_dec[i] = 1'b0;
    end
  end

  // next_edge is the number of the sclk edge produced by the current wrap.
  always_comb begin
    wrap       = (cnt == div_q);
    next_edge  = edge_cnt + 1'b1;
    last_edge  = (next_edge == EW'(2 * F));
    sample_now = cpha_q ? ~next_edge[0] : next_edge[0];
    shift_now  = cpha_q ? next_edge[0] : ~next_edge[0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      div_q    <= '0;
      edge_cnt <= '0;
      tx       <= '0;
      rx       <= '0;
      cpha_q   <= 1'b0;
      wr_q     <= 1'b0;
      rdata    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ss       <= '1;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            div_q    <= div;
            cnt      <= '0;
            edge_cnt <= '0;
            cpha_q   <= mode[0];
            wr_q     <= wr;
            sclk     <= mode[1];
            ss       <= ss_dec;
            busy     <= 1'b1;
            state    <= LEAD;
            // CPHA=0 presents the first bit immediately, so tx already holds the rest.
            if (mode[0]) begin
              tx   <= frame;
              mosi <= 1'b0;
            end else begin
              tx   <= frame << 1;
              mosi <= frame[F-1];
            end
          end
        end
        LEAD: begin
          if (wrap) begin
            cnt   <= '0;
            state <= XFER;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        XFER: begin
          if (wrap) begin
            cnt      <= '0;
            sclk     <= ~sclk;
            edge_cnt <= next_edge;
            if (sample_now) rx <= DATA_W'({rx, miso});
            if (last_edge) begin
              mosi  <= 1'b0;
              state <= TRAIL;
            end else if (shift_now) begin
              mosi <= tx[F-1];
              tx   <= tx << 1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        TRAIL: begin
          if (wrap) begin
            cnt   <= '0;
            ss    <= '1;
            state <= GUARD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GUARD: begin
          if (wrap) begin
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
            if (!wr_q) rdata <= rx;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_gen.sv
// Directed bench for spi_master_gen: a cycle-sampled SPI slave model drives miso
// and captures mosi, while each directed step checks timing and read data.
module tb_spi_master_gen;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       wr = 1'b0;
  logic [1:0] cs_sel = 2'd0;
  logic [1:0] mode = 2'd0;
  logic [9:0] div = 10'd0;
  logic [7:0] addr = 8'h00;
  logic [7:0] wdata = 8'h00;
  logic [7:0] rdata;
  logic       busy;
  logic       done;
  logic [3:0] ss;
  logic       sclk;
  logic       mosi;
  logic       miso;

  logic       loopback = 1'b0;
  logic       slave_miso = 1'b0;

  int tests = 0;
  int fails = 0;

  int          mon_sel;
  logic        slave_cpol;
  logic        slave_cpha;
  logic [23:0] resp;
  logic [23:0] cap;
  int          bit_ptr;
  int          rise_cnt;
  int          ss_low_cnt;
  int          gap_cnt;
  int          done_cycle;
  int          n;
  logic        prev_sclk;
  logic        prev_ss_low;
  logic        prev_mosi;

  assign miso = loopback ? mosi : slave_miso;

  always #5 clock = ~clock;

  spi_master_gen dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .wr     (wr),
    .cs_sel (cs_sel),
    .mode   (mode),
    .div    (div),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .busy   (busy),
    .done   (done),
    .ss     (ss),
    .sclk   (sclk),
    .mosi   (mosi),
    .miso   (miso)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Slave model, called once per negedge: shifts resp out on miso and captures
  // the mosi level present just before every rising sclk edge.
  task monitorStep();
    logic cur_sclk;
    logic cur_ss_low;
    logic leading;
    cur_sclk   = sclk;
    cur_ss_low = (ss[mon_sel] == 1'b0);
    if (busy && !cur_ss_low) gap_cnt++;
    if (prev_ss_low && cur_ss_low && (cur_sclk != prev_sclk)) begin
      if (cur_sclk) begin
        rise_cnt++;
        cap = {cap[22:0], prev_mosi};
      end
      leading = (cur_sclk != slave_cpol);
      if (slave_cpha && leading) begin
        slave_miso = resp[bit_ptr];
        if (bit_ptr > 0) bit_ptr--;
      end else if (!slave_cpha && !leading && bit_ptr > 0) begin
        bit_ptr--;
        slave_miso = resp[bit_ptr];
      end
    end
    if (!cur_ss_low) begin
      bit_ptr    = 23;
      slave_miso = slave_cpha ? 1'b0 : resp[23];
    end else begin
      ss_low_cnt++;
    end
    prev_sclk   = cur_sclk;
    prev_ss_low = cur_ss_low;
    prev_mosi   = mosi;
  endtask

  // Drives one request and returns just after the accept edge (cycle 0).
  task applyStimulus(input logic w, input logic [1:0] cs, input logic [1:0] md, input logic [9:0] d,
                     input logic [7:0] a, input logic [7:0] wd, input logic [7:0] slave_byte, input logic lb);
    @(negedge clock);
    wr = w; cs_sel = cs; mode = md; div = d; addr = a; wdata = wd; loopback = lb;
    mon_sel = int'(cs); slave_cpol = md[1]; slave_cpha = md[0];
    resp = {16'h0000, slave_byte};
    cap = '0; rise_cnt = 0; ss_low_cnt = 0; gap_cnt = 0; done_cycle = 0; n = 0;
    prev_sclk = sclk; prev_ss_low = 1'b0; prev_mosi = mosi;
    bit_ptr = 23; slave_miso = 1'b0;
    start = 1'b1;
    @(posedge clock);
  endtask

  task waitDone(input int limit, input logic hold);
    while (done_cycle == 0 && n < limit) begin
      @(negedge clock);
      n++;
      if (!hold) start = 1'b0;
      monitorStep();
      if (done) done_cycle = n;
    end
  endtask

  initial begin
    int d1;
    int d2;
    int done_seen;

    // Reset held for three cycles.
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("rst_ss", 32'(ss), 32'hf);
    checkOutput("rst_sclk", 32'(sclk), 32'h0);
    checkOutput("rst_mosi", 32'(mosi), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_done", 32'(done), 32'h0);
    checkOutput("rst_rdata", 32'(rdata), 32'h0);
    reset = 1'b0;

    // Mode 0 write, D=2: ss low cycles 1..100, done in cycle 2*51+1.
    applyStimulus(1'b1, 2'd2, 2'd0, 10'd1, 8'h5A, 8'hC3, 8'h00, 1'b0);
    waitDone(400, 1'b0);
    checkOutput("m0w_done_cycle", 32'(done_cycle), 32'd103);
    checkOutput("m0w_busy_at_done", 32'(busy), 32'h0);
    checkOutput("m0w_ss_low", 32'(ss_low_cnt), 32'd100);
    checkOutput("m0w_rises", 32'(rise_cnt), 32'd24);
    checkOutput("m0w_mosi", 32'(cap), 32'hff5ac3);
    checkOutput("m0w_rdata", 32'(rdata), 32'h0);

    // Mode 3 read, D=1: done in cycle 52, slave returns A5.
    applyStimulus(1'b0, 2'd0, 2'd3, 10'd0, 8'h10, 8'hEE, 8'hA5, 1'b0);
    waitDone(200, 1'b0);
    checkOutput("m3r_done_cycle", 32'(done_cycle), 32'd52);
    checkOutput("m3r_mosi", 32'(cap), 32'h001000);
    checkOutput("m3r_rises", 32'(rise_cnt), 32'd24);
    checkOutput("m3r_rdata", 32'(rdata), 32'ha5);
    checkOutput("m3r_sclk_idle", 32'(sclk), 32'h1);

    // Mode 1 loopback write, D=3: rdata untouched.
    applyStimulus(1'b1, 2'd1, 2'd1, 10'd2, 8'h33, 8'h7E, 8'h00, 1'b1);
    waitDone(400, 1'b0);
    checkOutput("m1w_done_cycle", 32'(done_cycle), 32'd154);
    checkOutput("m1w_rdata", 32'(rdata), 32'ha5);

    // Mode 1 loopback read: data field goes out as zeros and comes back.
    applyStimulus(1'b0, 2'd1, 2'd1, 10'd2, 8'h44, 8'hFF, 8'h00, 1'b1);
    waitDone(400, 1'b0);
    checkOutput("m1r_done_cycle", 32'(done_cycle), 32'd154);
    checkOutput("m1r_rdata", 32'(rdata), 32'h00);

    // Mode 2 slave read then mode 2 loopback read.
    applyStimulus(1'b0, 2'd3, 2'd2, 10'd2, 8'h21, 8'h00, 8'h96, 1'b0);
    waitDone(400, 1'b0);
    checkOutput("m2r_rdata", 32'(rdata), 32'h96);
    checkOutput("m2r_sclk_idle", 32'(sclk), 32'h1);
    applyStimulus(1'b0, 2'd3, 2'd2, 10'd2, 8'h21, 8'h00, 8'h00, 1'b1);
    waitDone(400, 1'b0);
    checkOutput("m2lb_rdata", 32'(rdata), 32'h00);

    // start held high: second transfer accepted in the done cycle.
    applyStimulus(1'b0, 2'd1, 2'd0, 10'd0, 8'h0F, 8'h00, 8'h3C, 1'b0);
    waitDone(200, 1'b1);
    d1 = done_cycle;
    checkOutput("b2b_first_done", 32'(d1), 32'd52);
    checkOutput("b2b_guard_gap", 32'(gap_cnt), 32'd1);
    d2 = 0;
    while (d2 == 0 && n < d1 + 200) begin
      @(negedge clock);
      n++;
      monitorStep();
      if (n == d1 + 1) checkOutput("b2b_relead_ss", 32'(ss[1]), 32'h0);
      if (done) begin
        d2 = n;
        start = 1'b0;
      end
    end
    checkOutput("b2b_done_spacing", 32'(d2 - d1), 32'd52);
    checkOutput("b2b_rdata", 32'(rdata), 32'h3c);
    @(negedge clock);
    checkOutput("b2b_no_third", 32'(busy), 32'h0);

    // Reset during cycle 40 of a mode 3 write.
    applyStimulus(1'b1, 2'd3, 2'd3, 10'd1, 8'hAA, 8'hFF, 8'h00, 1'b0);
    while (n < 40) begin
      @(negedge clock);
      n++;
      start = 1'b0;
      monitorStep();
    end
    reset = 1'b1;
    @(negedge clock);
    checkOutput("mid_rst_ss", 32'(ss), 32'hf);
    checkOutput("mid_rst_sclk", 32'(sclk), 32'h0);
    checkOutput("mid_rst_mosi", 32'(mosi), 32'h0);
    checkOutput("mid_rst_busy", 32'(busy), 32'h0);
    checkOutput("mid_rst_done", 32'(done), 32'h0);
    checkOutput("mid_rst_rdata", 32'(rdata), 32'h0);
    reset = 1'b0;
    done_seen = 0;
    repeat (120) begin
      @(negedge clock);
      if (done) done_seen++;
    end
    checkOutput("mid_rst_no_done", 32'(done_seen), 32'd0);

    // A fresh transfer after the aborted one behaves normally.
    applyStimulus(1'b1, 2'd0, 2'd0, 10'd0, 8'h12, 8'h34, 8'h00, 1'b0);
    waitDone(200, 1'b0);
    checkOutput("post_rst_done_cycle", 32'(done_cycle), 32'd52);
    checkOutput("post_rst_ss_low", 32'(ss_low_cnt), 32'd50);
    checkOutput("post_rst_mosi", 32'(cap), 32'hff1234);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
